// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised, byte-addressed little-endian store with a fixed-latency busy_wait stall.
// Optional build macro MISALIGN_ERR_EN adds the misalign_err port and suppresses misaligned accesses.
//
// state  | meaning
// S_IDLE | waiting for d_mem_r/d_mem_w; busy_wait follows the request combinationally
// S_BUSY | latency count running on captured request; access performed when cnt hits LATENCY
// S_DONE | one-cycle release of the core; new requests ignored
module data_mem_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        d_mem_r,
   input  logic        d_mem_w,
   input  logic [2:0]  fun_3,
   input  logic [31:0] address,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        busy_wait
`ifdef MISALIGN_ERR_EN
   ,
   output logic        misalign_err
`endif
);

   localparam int WORDS = 2 ** (ADDR_W - 2);
   localparam int CNT_W = $clog2(LATENCY + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic              op_r;
   logic              op_w;
   logic [2:0]        cap_f3;
   logic [ADDR_W-1:0] cap_addr;
   logic [31:0]       cap_wdata;

   logic [31:0]       mem [WORDS];

   logic              size_byte;
   logic              size_half;
   logic              access_fire;
   logic              access_ok;
   logic [1:0]        lane;
   logic [ADDR_W-3:0] word_idx;
   logic [31:0]       rd_word;
   logic [31:0]       rd_shift;
   logic [31:0]       load_val;
   logic [3:0]        byte_en;
   logic [31:0]       wr_lanes;

   logic              unused_addr_hi;
   assign unused_addr_hi = ^address[31:ADDR_W];

   assign size_byte = (cap_f3 == 3'b000) || (cap_f3 == 3'b100);
   assign size_half = (cap_f3 == 3'b001) || (cap_f3 == 3'b101);

`ifdef MISALIGN_ERR_EN
   logic misaligned;
   assign misaligned = (size_half && cap_addr[0]) ||
                       (!size_byte && !size_half && (cap_addr[1:0] != 2'b00));
   assign access_ok  = !misaligned;
`else
   assign access_ok  = 1'b1;
`endif

   // Non-byte accesses use the naturally aligned lane; low address bits are dropped.
   always_comb begin
      lane = 2'b00;
      if (size_byte)
         lane = cap_addr[1:0];
      else if (size_half)
         lane = {cap_addr[1], 1'b0};
   end

   assign word_idx    = cap_addr[ADDR_W-1:2];
   assign rd_word     = mem[word_idx];
   assign rd_shift    = rd_word >> {lane, 3'b000};
   assign access_fire = (state == S_BUSY) && (cnt == CNT_W'(LATENCY));

   always_comb begin
      load_val = rd_word;
      if (size_byte)
         load_val = {{24{rd_shift[7] & ~cap_f3[2]}}, rd_shift[7:0]};
      else if (size_half)
         load_val = {{16{rd_shift[15] & ~cap_f3[2]}}, rd_shift[15:0]};
   end

   always_comb begin
      byte_en  = 4'b1111;
      wr_lanes = cap_wdata;
      if (size_byte) begin
         byte_en  = 4'b0001 << lane;
         wr_lanes = {4{cap_wdata[7:0]}};
      end else if (size_half) begin
         byte_en  = 4'b0011 << lane;
         wr_lanes = {2{cap_wdata[15:0]}};
      end
   end

   // Memory is not reset; a reset during BUSY drops the FSM to IDLE so the store never fires.
   always_ff @(posedge clock) begin
      if (access_fire && op_w && access_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i])
               mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         op_r      <= 1'b0;
         op_w      <= 1'b0;
         cap_f3    <= 3'b000;
         cap_addr  <= '0;
         cap_wdata <= '0;
         readdata  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (d_mem_r || d_mem_w) begin
                  op_r      <= d_mem_r;
                  op_w      <= d_mem_w & ~d_mem_r;
                  cap_f3    <= fun_3;
                  cap_addr  <= address[ADDR_W-1:0];
                  cap_wdata <= writedata;
                  cnt       <= CNT_W'(1);
                  state     <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (access_fire) begin
                  if (op_r)
                     readdata <= access_ok ? load_val : 32'h0;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef MISALIGN_ERR_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         misalign_err <= 1'b0;
      else
         misalign_err <= access_fire && misaligned;
   end
`endif

   // busy_wait is gated by reset_n so a request still held during reset cannot stall the core.
   always_comb begin
      busy_wait = 1'b0;
      case (state)
         S_IDLE:  busy_wait = reset_n & (d_mem_r | d_mem_w);
         S_BUSY:  busy_wait = 1'b1;
         default: busy_wait = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed cases plus randomized accesses
// against a byte-array reference model. Honours MISALIGN_ERR_EN when defined.
module tb_data_mem_responder;

   localparam int LAT = 4;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        d_mem_r;
   logic        d_mem_w;
   logic [2:0]  fun_3;
   logic [31:0] address;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        busy_wait;
`ifdef MISALIGN_ERR_EN
   logic        misalign_err;
`endif

   always #5 clock = ~clock;

   data_mem_responder #(.ADDR_W(10), .LATENCY(LAT)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .d_mem_r     (d_mem_r),
      .d_mem_w     (d_mem_w),
      .fun_3       (fun_3),
      .address     (address),
      .writedata   (writedata),
      .readdata    (readdata),
      .busy_wait   (busy_wait)
`ifdef MISALIGN_ERR_EN
      ,
      .misalign_err(misalign_err)
`endif
   );

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  mm [64];
   logic [31:0] last_rd;
   logic [31:0] obs_rd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] f);
      if (f == 3'b000 || f == 3'b100) return 1;
      if (f == 3'b001 || f == 3'b101) return 2;
      return 4;
   endfunction

   function automatic bit is_misaligned(input logic [2:0] f, input logic [31:0] a);
      int s = size_of(f);
      return (a % s) != 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a);
      int s = size_of(f);
      int o = int'(a % 64);
      logic [31:0] v = 32'h0;
`ifdef MISALIGN_ERR_EN
      if (is_misaligned(f, a)) return 32'h0;
`else
      o = o - (o % s);
`endif
      for (int i = 0; i < s; i++)
         v = v + (32'(mm[o+i]) << (8*i));
      if (s < 4 && !f[2] && v[8*s-1])
         v = v | (32'hFFFF_FFFF << (8*s));
      return v;
   endfunction

   task automatic model_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
      int s = size_of(f);
      int o = int'(a % 64);
`ifdef MISALIGN_ERR_EN
      if (is_misaligned(f, a)) return;
`else
      o = o - (o % s);
`endif
      for (int i = 0; i < s; i++)
         mm[o+i] = d[8*i +: 8];
   endtask

   task automatic access(input logic r, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d, input string tag);
      logic [31:0] exp;
      int busy_n;
      exp = r ? model_load(f, a) : last_rd;
      @(negedge clock);
      d_mem_r   = r;
      d_mem_w   = w;
      fun_3     = f;
      address   = a;
      writedata = d;
      #1;
      busy_n = 0;
      while (busy_wait === 1'b1 && busy_n < 20) begin
         busy_n++;
         @(negedge clock);
         #1;
      end
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(LAT + 1));
      check({tag, "_readdata"}, readdata, exp);
`ifdef MISALIGN_ERR_EN
      check({tag, "_misalign"}, 32'(misalign_err), 32'(is_misaligned(f, a)));
`endif
      obs_rd  = readdata;
      d_mem_r = 1'b0;
      d_mem_w = 1'b0;
      if (r)
         last_rd = exp;
      else if (w)
         model_store(f, a, d);
   endtask

   initial begin
      reset_n   = 1'b0;
      d_mem_r   = 1'b0;
      d_mem_w   = 1'b0;
      fun_3     = 3'b000;
      address   = 32'h0;
      writedata = 32'h0;
      last_rd   = 32'h0;
      obs_rd    = 32'h0;
      repeat (3) @(negedge clock);
      check("rst_busy", 32'(busy_wait), 32'h0);
      check("rst_readdata", readdata, 32'h0);
`ifdef MISALIGN_ERR_EN
      check("rst_misalign", 32'(misalign_err), 32'h0);
`endif
      reset_n = 1'b1;

      for (int i = 0; i < 16; i++)
         access(1'b0, 1'b1, 3'b010, 32'(i * 4), $urandom(), "init");

      access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, "sw_deadbeef");
      access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "lw_10");
      check("lw_10_const", obs_rd, 32'hDEAD_BEEF);
      access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, "lb_13");
      check("lb_13_const", obs_rd, 32'hFFFF_FFDE);
      access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, "lbu_13");
      check("lbu_13_const", obs_rd, 32'h0000_00DE);
      access(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, "lhu_12");
      check("lhu_12_const", obs_rd, 32'h0000_DEAD);
      access(1'b1, 1'b0, 3'b001, 32'h10, 32'h0, "lh_10");
      check("lh_10_const", obs_rd, 32'hFFFF_BEEF);

      access(1'b0, 1'b1, 3'b000, 32'h11, 32'h1234_5677, "sb_11");
      check("sb_holds_readdata", obs_rd, 32'hFFFF_BEEF);
      access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "lw_after_sb");
      check("sb_11_const", obs_rd, 32'hDEAD_77EF);
      access(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000_AAAA, "sh_12");
      access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "lw_after_sh");
      check("sh_12_const", obs_rd, 32'hAAAA_77EF);

      // Reset mid-store with the request still held: store must not land.
      @(negedge clock);
      d_mem_w   = 1'b1;
      fun_3     = 3'b010;
      address   = 32'h10;
      writedata = 32'h0;
      repeat (2) @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy_wait), 32'h0);
      check("abort_readdata", readdata, 32'h0);
      d_mem_w = 1'b0;
      last_rd = 32'h0;
      @(negedge clock);
      reset_n = 1'b1;
      access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "lw_after_abort");
      check("abort_mem_const", obs_rd, 32'hAAAA_77EF);

      access(1'b1, 1'b1, 3'b010, 32'h10, 32'h5555_5555, "rw_both");
      access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "lw_after_both");
      check("both_mem_const", obs_rd, 32'hAAAA_77EF);
      access(1'b1, 1'b0, 3'b010, 32'h410, 32'h0, "lw_alias");
      check("alias_const", obs_rd, 32'hAAAA_77EF);

      access(1'b1, 1'b0, 3'b010, 32'h12, 32'h0, "lw_misal");
`ifdef MISALIGN_ERR_EN
      check("misal_const", obs_rd, 32'h0);
`else
      check("misal_const", obs_rd, 32'hAAAA_77EF);
`endif

      for (int n = 0; n < 300; n++) begin
         int sel;
         logic [31:0] a;
         sel = int'($urandom_range(0, 2));
         a   = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
         access(sel != 1, sel != 0, 3'($urandom_range(0, 7)), a, $urandom(), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
